sc_collision_nv: RTL and testbench

Consumer and level controller for the vehicle-row pattern bus. Samples the 8-bit shifting vehicle pattern produced by the level-driven vehicle row register, which is clocked from a level-selected divided clock. Compares the pattern against the frog's column and reports confirmed collisions. Owns the lives counter, and drives the level code and change-level pulse (`NVL`/`CN`) back into the vehicle row registers, closing the level loop from the consumer end.

---
 rtl/sc_collision_nv_pkg.sv | 36 +++
 rtl/sc_collision_nv_rowbus_sampler.sv | 59 +++++
 rtl/sc_collision_nv.sv | 189 ++++++++++++++++++
 tb/tb_sc_collision_nv.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_collision_nv_pkg.sv
// -----------------------------------------------------------------------------
// sc_collision_nv_pkg
//
// Shared definitions for the collision / level controller and the vehicle-row
// level decoder:
//   - FSM state encoding of the collision controller
//   - default lives, hit-confirmation and holdoff lengths
//   - level code width and the highest level code
//   - a small helper for sizing "count to N-1" counters
// -----------------------------------------------------------------------------
package sc_collision_nv_pkg;

    // Controller states. PLAY is the reset state.
    typedef enum logic [2:0] {
        ST_PLAY    = 3'd0,
        ST_HIT     = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_LEVELUP = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    // Game defaults.
    localparam int LIVES_INIT_DEFAULT     = 3;
    localparam int HIT_CYCLES_DEFAULT     = 2;
    localparam int HOLDOFF_CYCLES_DEFAULT = 16;

    // Level code shared with the vehicle-row level decoder.
    localparam int DATAWIDTH_NIVEL_DEFAULT = 2;
    localparam int NIVEL_MAX               = 3;

    // Width of a counter that must hold the values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sc_collision_nv_rowbus_sampler.sv
// -----------------------------------------------------------------------------
// sc_rowbus_sampler
//
// Brings the vehicle pattern (which moves on a divided-clock edge) into the
// system clock through two register stages, and decides whether the current
// cycle is a qualifying collision cycle for the frog's column.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   row_bus      in   vehicle pattern, 1 = vehicle in that column
//   frog_pos     in   frog column index
//   frog_on_row  in   frog occupies this row
//   qualify      out  stable pattern, frog on row, vehicle in frog's column
// -----------------------------------------------------------------------------
module sc_rowbus_sampler
    import sc_collision_nv_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int DATAWIDTH_POS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATAWIDTH_BUS-1:0] row_bus,
    input  logic [DATAWIDTH_POS-1:0] frog_pos,
    input  logic                     frog_on_row,
    output logic                     qualify
);

    logic [DATAWIDTH_BUS-1:0] s1_reg;
    logic [DATAWIDTH_BUS-1:0] s2_reg;
    logic [DATAWIDTH_BUS-1:0] col_match;
    logic                     stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= row_bus;
            s2_reg <= s1_reg;
        end
    end

    // Two equal consecutive samples mean the pattern is not mid-shift.
    assign stable = (s1_reg == s2_reg);

    // One comparator per column: a column only matches when the frog index
    // equals that column number, so indices >= DATAWIDTH_BUS never match and
    // no out-of-range select is ever formed.
    generate
        for (genvar gi = 0; gi < DATAWIDTH_BUS; gi++) begin : g_col
            assign col_match[gi] = s2_reg[gi] && (frog_pos == DATAWIDTH_POS'(gi));
        end
    endgenerate

    assign qualify = stable && frog_on_row && (|col_match);

endmodule

// File: rtl/sc_collision_nv.sv
// -----------------------------------------------------------------------------
// sc_collision_nv
//
// Collision detector and level controller for one vehicle row. Samples the
// shifting vehicle pattern, confirms collisions with the frog, keeps the lives
// counter and drives the level code / change-level pulse back to the vehicle
// row registers.
//
// Ports:
//   SC_COLLISION_NV_CLOCK_50        in   system clock
//   SC_COLLISION_NV_RESET           in   asynchronous active-low reset
//   SC_COLLISION_NV_ROW_BUS_IN      in   vehicle pattern
//   SC_COLLISION_NV_FROG_POS_IN     in   frog column
//   SC_COLLISION_NV_FROG_ON_ROW_IN  in   frog occupies this row (level)
//   SC_COLLISION_NV_GOAL_IN         in   frog reached the far bank (pulse)
//   SC_COLLISION_NV_START_IN        in   restart game (pulse)
//   SC_COLLISION_NV_COLLISION_OUT   out  one pulse per confirmed hit
//   SC_COLLISION_NV_LIVES_OUT       out  remaining lives
//   SC_COLLISION_NV_NVL_OUT         out  level code to the vehicle rows
//   SC_COLLISION_NV_CN_OUT          out  change-level pulse to the vehicle rows
//   SC_COLLISION_NV_GAMEOVER_OUT    out  no lives left (level)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module sc_collision_nv
    import sc_collision_nv_pkg::*;
#(
    parameter int DATAWIDTH_BUS     = 8,
    parameter int DATAWIDTH_POS     = 3,
    parameter int DATAWIDTH_NIVEL   = DATAWIDTH_NIVEL_DEFAULT,
    parameter int DATAWIDTH_LIVES   = 2,
    parameter int LIVES_INIT        = LIVES_INIT_DEFAULT,
    parameter int HIT_CYCLES        = HIT_CYCLES_DEFAULT,
    parameter int HOLDOFF_CYCLES    = HOLDOFF_CYCLES_DEFAULT,
    parameter int DATAWIDTH_HOLDOFF = 5
) (
    input  logic                       SC_COLLISION_NV_CLOCK_50,
    input  logic                       SC_COLLISION_NV_RESET,
    input  logic [DATAWIDTH_BUS-1:0]   SC_COLLISION_NV_ROW_BUS_IN,
    input  logic [DATAWIDTH_POS-1:0]   SC_COLLISION_NV_FROG_POS_IN,
    input  logic                       SC_COLLISION_NV_FROG_ON_ROW_IN,
    input  logic                       SC_COLLISION_NV_GOAL_IN,
    input  logic                       SC_COLLISION_NV_START_IN,
    output logic                       SC_COLLISION_NV_COLLISION_OUT,
    output logic [DATAWIDTH_LIVES-1:0] SC_COLLISION_NV_LIVES_OUT,
    output logic [DATAWIDTH_NIVEL-1:0] SC_COLLISION_NV_NVL_OUT,
    output logic                       SC_COLLISION_NV_CN_OUT,
    output logic                       SC_COLLISION_NV_GAMEOVER_OUT
);

    localparam int HIT_CNT_W = cnt_width(HIT_CYCLES);

    localparam logic [HIT_CNT_W-1:0]         HIT_LAST     = HIT_CNT_W'(HIT_CYCLES - 1);
    localparam logic [DATAWIDTH_HOLDOFF-1:0] HOLDOFF_LAST = DATAWIDTH_HOLDOFF'(HOLDOFF_CYCLES - 1);
    localparam logic [DATAWIDTH_NIVEL-1:0]   NVL_TOP      = DATAWIDTH_NIVEL'(NIVEL_MAX);
    localparam logic [DATAWIDTH_LIVES-1:0]   LIVES_LOAD   = DATAWIDTH_LIVES'(LIVES_INIT);

    logic clk;
    logic rst_n;
    assign clk   = SC_COLLISION_NV_CLOCK_50;
    assign rst_n = SC_COLLISION_NV_RESET;

    logic qualify;

    state_t                       state_reg;
    logic [HIT_CNT_W-1:0]         hit_cnt_reg;
    logic [DATAWIDTH_HOLDOFF-1:0] holdoff_cnt_reg;
    logic [DATAWIDTH_LIVES-1:0]   lives_reg;
    logic [DATAWIDTH_NIVEL-1:0]   nvl_reg;
    logic                         collision_reg;
    logic                         cn_reg;
    logic                         gameover_reg;

    // ------------------------------------------------------------------
    // Pattern sampling and column qualification
    // ------------------------------------------------------------------
    sc_rowbus_sampler #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS),
        .DATAWIDTH_POS (DATAWIDTH_POS)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_bus     (SC_COLLISION_NV_ROW_BUS_IN),
        .frog_pos    (SC_COLLISION_NV_FROG_POS_IN),
        .frog_on_row (SC_COLLISION_NV_FROG_ON_ROW_IN),
        .qualify     (qualify)
    );

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_PLAY;
            hit_cnt_reg     <= '0;
            holdoff_cnt_reg <= '0;
            lives_reg       <= LIVES_LOAD;
            nvl_reg         <= '0;
            collision_reg   <= 1'b0;
            cn_reg          <= 1'b0;
            gameover_reg    <= 1'b0;
        end else begin
            // Pulse outputs are high for one cycle only, unless set below.
            collision_reg <= 1'b0;
            cn_reg        <= 1'b0;

            if (SC_COLLISION_NV_START_IN) begin
                // Restart behaves like a level-up that reloads the game
                // instead of advancing the level.
                state_reg       <= ST_LEVELUP;
                hit_cnt_reg     <= '0;
                holdoff_cnt_reg <= '0;
                lives_reg       <= LIVES_LOAD;
                nvl_reg         <= '0;
                cn_reg          <= 1'b1;
                gameover_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_PLAY: begin
                        if (qualify && (hit_cnt_reg == HIT_LAST)) begin
                            // Confirmed hit wins over a simultaneous goal.
                            state_reg     <= ST_HIT;
                            hit_cnt_reg   <= '0;
                            lives_reg     <= lives_reg - DATAWIDTH_LIVES'(1);
                            collision_reg <= 1'b1;
                        end else if (SC_COLLISION_NV_GOAL_IN) begin
                            state_reg   <= ST_LEVELUP;
                            hit_cnt_reg <= '0;
                            cn_reg      <= 1'b1;
                            if (nvl_reg != NVL_TOP) begin
                                nvl_reg <= nvl_reg + DATAWIDTH_NIVEL'(1);
                            end
                        end else if (qualify) begin
                            hit_cnt_reg <= hit_cnt_reg + HIT_CNT_W'(1);
                        end else begin
                            hit_cnt_reg <= '0;
                        end
                    end

                    ST_HIT: begin
                        // Lives were already decremented on entry.
                        if (lives_reg == '0) begin
                            state_reg    <= ST_OVER;
                            gameover_reg <= 1'b1;
                        end else begin
                            state_reg       <= ST_HOLDOFF;
                            holdoff_cnt_reg <= '0;
                        end
                    end

                    ST_LEVELUP: begin
                        state_reg       <= ST_HOLDOFF;
                        holdoff_cnt_reg <= '0;
                    end

                    ST_HOLDOFF: begin
                        // Counter value k means k+1 holdoff edges have
                        // passed, so the last value returns to PLAY exactly
                        // HOLDOFF_CYCLES edges after entering.
                        if (holdoff_cnt_reg == HOLDOFF_LAST) begin
                            state_reg       <= ST_PLAY;
                            holdoff_cnt_reg <= '0;
                            hit_cnt_reg     <= '0;
                        end else begin
                            holdoff_cnt_reg <= holdoff_cnt_reg + DATAWIDTH_HOLDOFF'(1);
                        end
                    end

                    ST_OVER: begin
                        // Only a restart leaves this state.
                        gameover_reg <= 1'b1;
                    end

                    default: begin
                        state_reg       <= ST_PLAY;
                        hit_cnt_reg     <= '0;
                        holdoff_cnt_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign SC_COLLISION_NV_COLLISION_OUT = collision_reg;
    assign SC_COLLISION_NV_LIVES_OUT     = lives_reg;
    assign SC_COLLISION_NV_NVL_OUT       = nvl_reg;
    assign SC_COLLISION_NV_CN_OUT        = cn_reg;
    assign SC_COLLISION_NV_GAMEOVER_OUT  = gameover_reg;

endmodule

// File: tb/tb_sc_collision_nv.sv
// -----------------------------------------------------------------------------
// tb_sc_collision_nv
//
// Directed bench for sc_collision_nv: a vector table for the first hit and the
// holdoff that follows it, then hand-written sequences for glitches, level-ups,
// game over, restart, simultaneous events and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_sc_collision_nv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus;
    logic [2:0] pos;
    logic       on_row;
    logic       goal;
    logic       start;
    logic       coll;
    logic [1:0] lives;
    logic [1:0] nvl;
    logic       cn;
    logic       go;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_collision_nv dut (
        .SC_COLLISION_NV_CLOCK_50       (clk),
        .SC_COLLISION_NV_RESET          (rst_n),
        .SC_COLLISION_NV_ROW_BUS_IN     (bus),
        .SC_COLLISION_NV_FROG_POS_IN    (pos),
        .SC_COLLISION_NV_FROG_ON_ROW_IN (on_row),
        .SC_COLLISION_NV_GOAL_IN        (goal),
        .SC_COLLISION_NV_START_IN       (start),
        .SC_COLLISION_NV_COLLISION_OUT  (coll),
        .SC_COLLISION_NV_LIVES_OUT      (lives),
        .SC_COLLISION_NV_NVL_OUT        (nvl),
        .SC_COLLISION_NV_CN_OUT         (cn),
        .SC_COLLISION_NV_GAMEOVER_OUT   (go)
    );

    typedef struct {
        logic [7:0] bus;
        logic [2:0] pos;
        logic       on;
        logic       coll;
        logic [1:0] lives;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [7:0] b, input logic [2:0] p,
                                input logic o, input logic c, input logic [1:0] l);
        vec_t v;
        v.bus = b; v.pos = p; v.on = o; v.coll = c; v.lives = l;
        vecs.push_back(v);
    endfunction

    // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic [7:0] b, input logic [2:0] p, input logic o,
                        input logic g, input logic s);
        @(negedge clk);
        bus = b; pos = p; on_row = o; goal = g; start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic e_coll, input logic [1:0] e_lives,
                           input logic [1:0] e_nvl, input logic e_cn, input logic e_go);
        checks++;
        if ({coll, lives, nvl, cn, go} !== {e_coll, e_lives, e_nvl, e_cn, e_go}) begin
            errors++;
            $display("FAIL %s: got coll=%b lives=%0d nvl=%0d cn=%b go=%b, expected coll=%b lives=%0d nvl=%0d cn=%b go=%b",
                     name, coll, lives, nvl, cn, go, e_coll, e_lives, e_nvl, e_cn, e_go);
        end
        $display("t=%0t %s coll=%b lives=%0d nvl=%0d cn=%b go=%b", $time, name, coll, lives, nvl, cn, go);
    endtask

    task automatic idle(input int n, input logic [1:0] l, input logic [1:0] nv);
        for (int k = 0; k < n; k++) begin
            step(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
            chk_out("idle", 1'b0, l, nv, 1'b0, 1'b0);
        end
    endtask

    // Hit from PLAY with s1 = s2 = 0: collision on the fourth edge, then one
    // follow-up edge that lands in HOLDOFF or OVER.
    task automatic hit_seq(input string name, input logic g, input logic [1:0] exp_l,
                           input logic [1:0] exp_nv);
        logic [1:0] prev_l;
        prev_l = exp_l + 2'd1;
        for (int k = 0; k < 3; k++) begin
            step(8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
            chk_out(name, 1'b0, prev_l, exp_nv, 1'b0, 1'b0);
        end
        step(8'h10, 3'd4, 1'b1, g, 1'b0);
        chk_out(name, 1'b1, exp_l, exp_nv, 1'b0, 1'b0);
        step(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_out(name, 1'b0, exp_l, exp_nv, 1'b0, (exp_l == 2'd0));
    endtask

    task automatic over_ignore(input logic [1:0] nv);
        for (int k = 0; k < 6; k++) begin
            step(8'h10, 3'd4, 1'b1, (k == 2), 1'b0);
            chk_out("over_ignore", 1'b0, 2'd0, nv, 1'b0, 1'b1);
        end
    endtask

    task automatic restart();
        step(8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        chk_out("start", 1'b0, 2'd3, 2'd0, 1'b1, 1'b0);
        step(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_out("start_after", 1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
        idle(16, 2'd3, 2'd0);
    endtask

    logic [1:0] lvl_exp [4];

    initial begin
        rst_n = 1'b0; bus = '0; pos = '0; on_row = 1'b0; goal = 1'b0; start = 1'b0;

        // First hit: edges 0..3, holdoff from edge 4, PLAY again at edge 20,
        // the persisting condition confirms a second hit at edge 22.
        for (int k = 0; k < 3; k++) add(8'h10, 3'd4, 1'b1, 1'b0, 2'd3);
        add(8'h10, 3'd4, 1'b1, 1'b1, 2'd2);
        for (int k = 4; k < 22; k++) add(8'h10, 3'd4, 1'b1, 1'b0, 2'd2);
        add(8'h10, 3'd4, 1'b1, 1'b1, 2'd1);
        add(8'h00, 3'd0, 1'b0, 1'b0, 2'd1);

        lvl_exp[0] = 2'd1; lvl_exp[1] = 2'd2; lvl_exp[2] = 2'd3; lvl_exp[3] = 2'd3;

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].bus, vecs[i].pos, vecs[i].on, 1'b0, 1'b0);
            chk_out($sformatf("vec%0d", i), vecs[i].coll, vecs[i].lives, 2'd0, 1'b0, 1'b0);
        end
        idle(16, 2'd1, 2'd0);

        // One-sample glitch on the frog's column.
        step(8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
        chk_out("glitch", 1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(8'h00, 3'd4, 1'b1, 1'b0, 1'b0);
            chk_out("glitch", 1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
        end
        // Vehicle present but frog in a different column.
        for (int k = 0; k < 6; k++) begin
            step(8'h10, 3'd3, 1'b1, 1'b0, 1'b0);
            chk_out("other_col", 1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
        end
        idle(3, 2'd1, 2'd0);
        // Frog column always occupied but pattern never stable.
        for (int k = 0; k < 8; k++) begin
            step((k % 2 == 0) ? 8'h10 : 8'h30, 3'd4, 1'b1, 1'b0, 1'b0);
            chk_out("unstable", 1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
        end
        idle(3, 2'd1, 2'd0);

        // Hit confirmed together with a goal: hit wins, level unchanged,
        // last life lost.
        hit_seq("simul", 1'b1, 2'd0, 2'd0);
        over_ignore(2'd0);
        restart();

        // Four level-ups, saturating at 3; a goal inside holdoff is ignored.
        for (int k = 0; k < 4; k++) begin
            step(8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
            chk_out("goal", 1'b0, 2'd3, lvl_exp[k], 1'b1, 1'b0);
            step(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
            chk_out("goal_after", 1'b0, 2'd3, lvl_exp[k], 1'b0, 1'b0);
            if (k == 0) begin
                step(8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
                chk_out("goal_holdoff", 1'b0, 2'd3, 2'd1, 1'b0, 1'b0);
                idle(15, 2'd3, 2'd1);
            end else begin
                idle(16, 2'd3, lvl_exp[k]);
            end
        end

        // Three hits to game over, then restart.
        hit_seq("hit1", 1'b0, 2'd2, 2'd3);
        idle(16, 2'd2, 2'd3);
        hit_seq("hit2", 1'b0, 2'd1, 2'd3);
        idle(16, 2'd1, 2'd3);
        hit_seq("hit3", 1'b0, 2'd0, 2'd3);
        over_ignore(2'd3);
        restart();

        // Reset during holdoff after a level-up.
        step(8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_out("goal_pre_rst", 1'b0, 2'd3, 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
            chk_out("holdoff_pre_rst", 1'b0, 2'd3, 2'd1, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1 chk_out("rst_holdoff", 1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Block restarts in PLAY: a hit follows with normal latency, and a
        // reset during HIT drops the pulse at once.
        for (int k = 0; k < 3; k++) begin
            step(8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
            chk_out("post_rst_hit", 1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
        end
        step(8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
        chk_out("post_rst_hit", 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_out("rst_hit", 1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 2'd3, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
